// File: rtl/event_beeper.sv
// event_beeper: turns single-cycle hit/score ticks into timed square-wave tones on one buzzer pin
module event_beeper #(
  parameter int unsigned HIT_HALF      = 50_000,
  parameter int unsigned HIT_DUR       = 10_000_000,
  parameter int unsigned SCORE_HI_HALF = 56_818,
  parameter int unsigned SCORE_LO_HALF = 113_636,
  parameter int unsigned SCORE_DUR     = 15_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic score,
  output logic beep,
  output logic busy
);
  localparam int unsigned HMAX0 = HIT_HALF > SCORE_HI_HALF ? HIT_HALF : SCORE_HI_HALF;
  localparam int unsigned HMAX = HMAX0 > SCORE_LO_HALF ? HMAX0 : SCORE_LO_HALF;
  localparam int unsigned DMAX = HIT_DUR > SCORE_DUR ? HIT_DUR : SCORE_DUR;
  localparam int HW = $clog2(HMAX + 1);
  localparam int DW = $clog2(DMAX + 1);
  typedef enum logic [1:0] {IDLE, HIT, SCORE_HI, SCORE_LO} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] half_q, half_d, half_lim;
  logic [DW-1:0] dur_q, dur_d, dur_lim;
  logic beep_q, beep_d, busy_q;
  always_comb begin
    half_lim = state_q == HIT ? HW'(HIT_HALF - 1) : state_q == SCORE_HI ? HW'(SCORE_HI_HALF - 1) : HW'(SCORE_LO_HALF - 1);
    dur_lim = state_q == HIT ? DW'(HIT_DUR - 1) : DW'(SCORE_DUR - 1);
    state_d = state_q;
    half_d = half_q + HW'(1);
    dur_d = dur_q + DW'(1);
    beep_d = beep_q;
    // events outrank tone-end so a tick on the last cycle still restarts
    if (score) begin
      state_d = SCORE_HI;
      half_d = '0;
      dur_d = '0;
      beep_d = 1'b1;
    end else if (hit && (state_q == IDLE || state_q == HIT)) begin
      state_d = HIT;
      half_d = '0;
      dur_d = '0;
      beep_d = 1'b1;
    end else if (state_q == IDLE) begin
      half_d = '0;
      dur_d = '0;
      beep_d = 1'b0;
    end else if (dur_q == dur_lim) begin
      state_d = state_q == SCORE_HI ? SCORE_LO : IDLE;
      half_d = '0;
      dur_d = '0;
      beep_d = state_q == SCORE_HI;
    end else if (half_q == half_lim) begin
      half_d = '0;
      beep_d = ~beep_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      half_q <= '0;
      dur_q <= '0;
      beep_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      dur_q <= dur_d;
      beep_q <= beep_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign beep = beep_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_event_beeper.sv
// tb_event_beeper: scoreboard bench; each driven cycle queues the {beep,busy} expected after the next edge
module tb_event_beeper;
  logic clk = 1'b0, rst = 1'b1, hit = 1'b0, score = 1'b0;
  logic beep, busy;
  int checks = 0, errors = 0;
  string tag = "reset";
  logic [1:0] exp_q[$];
  localparam logic [7:0] HIT_PAT = 8'b11001100;
  localparam logic [11:0] SCORE_PAT = 12'b101010_111000;

  event_beeper #(.HIT_HALF(2), .HIT_DUR(8), .SCORE_HI_HALF(1), .SCORE_LO_HALF(3), .SCORE_DUR(6)) dut (
    .clk(clk), .rst(rst), .hit(hit), .score(score), .beep(beep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string t, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", t, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (exp_q.size() != 0) check(tag, int'({beep, busy}), int'(exp_q.pop_front()));

  task automatic cyc(input logic h, input logic s, input logic [1:0] e);
    @(negedge clk);
    #1;
    hit = h;
    score = s;
    exp_q.push_back(e);
  endtask

  function automatic logic [1:0] hit_at(input int i);
    logic [7:0] p = HIT_PAT;
    return {p[7-i], 1'b1};
  endfunction

  function automatic logic [1:0] score_at(input int i);
    logic [11:0] p = SCORE_PAT;
    return {p[11-i], 1'b1};
  endfunction

  initial begin
    #3 check("reset_held", int'({beep, busy}), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    tag = "idle";
    repeat (4) cyc(0, 0, 2'b00);
    tag = "single_hit";
    for (int k = 0; k < 8; k++) cyc(k == 0, 0, hit_at(k));
    repeat (2) cyc(0, 0, 2'b00);
    tag = "score_seq";
    for (int k = 0; k < 12; k++) cyc(0, k == 0, score_at(k));
    repeat (2) cyc(0, 0, 2'b00);
    tag = "hit_and_score";
    for (int k = 0; k < 12; k++) cyc(k == 0, k == 0, score_at(k));
    cyc(0, 0, 2'b00);
    tag = "hit_in_lo_ignored";
    for (int k = 0; k < 12; k++) cyc(k == 9, k == 0, score_at(k));
    cyc(0, 0, 2'b00);
    tag = "score_preempts_hit";
    for (int k = 0; k < 5; k++) cyc(k == 0, 0, hit_at(k));
    for (int k = 0; k < 12; k++) cyc(0, k == 0, score_at(k));
    cyc(0, 0, 2'b00);
    tag = "hit_retrigger";
    for (int k = 0; k < 6; k++) cyc(k == 0, 0, hit_at(k));
    for (int k = 0; k < 8; k++) cyc(k == 0, 0, hit_at(k));
    cyc(0, 0, 2'b00);
    tag = "score_retrigger";
    for (int k = 0; k < 8; k++) cyc(0, k == 0, score_at(k));
    for (int k = 0; k < 12; k++) cyc(0, k == 0, score_at(k));
    cyc(0, 0, 2'b00);
    tag = "mid_tone";
    for (int k = 0; k < 3; k++) cyc(0, k == 0, score_at(k));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", int'({beep, busy}), 0);
    tag = "reset_hold";
    repeat (2) cyc(0, 0, 2'b00);
    rst = 1'b0;
    tag = "hit_after_reset";
    for (int k = 0; k < 8; k++) cyc(k == 0, 0, hit_at(k));
    cyc(0, 0, 2'b00);
    @(negedge clk);
    #1 check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
